atm_session_ctrl: RTL and testbench

- Next-generation ATM session controller: multi-account, parametrised successor to the current ATM top-level.
- Internalises the following, which the current design spreads across separate blocks:
  - account storage (PIN and balance per account)
  - PIN retry counting with card lockout
  - inactivity timeout
  - the operation FSM
- Sits between the card/keypad front end and the display/dispenser logic.
- Single clock domain.

---
 rtl/atm_pkg.sv | 24 ++
 rtl/atm_session_timer.sv | 36 +++
 rtl/atm_session_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM state encoding,
// operation codes and a small state classification helper.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_WAIT_PIN = 3'd2,
    ST_MENU     = 3'd3,
    ST_EXEC     = 3'd4,
    ST_EJECT    = 3'd5
  } atm_state_t;

  localparam logic [1:0] OP_INQ  = 2'b00;
  localparam logic [1:0] OP_DEP  = 2'b01;
  localparam logic [1:0] OP_WD   = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

  // States in which the customer is expected to act and inactivity is timed.
  function automatic logic is_timed_state(input atm_state_t s);
    return (s == ST_WAIT_PIN) || (s == ST_MENU);
  endfunction

endpackage

// File: rtl/atm_session_timer.sv
// Inactivity down-counter. While load is high the counter sits at its
// reload value; while enabled it counts down and flags expiry on the cycle
// that completes TIMEOUT_CYCLES enabled cycles. A load in the expiry cycle
// suppresses expiry so that customer input always wins over the timeout.
module atm_session_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Reload on request, otherwise count down while enabled and saturate at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= RELOAD;
    end else if (load) begin
      count_r <= RELOAD;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = en && !load && (count_r == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// Multi-account ATM session controller: account storage, PIN retry
// lockout, inactivity timeout and the operation FSM in one block.
// Optional feature: define ATM_DAILY_LIMIT_EN to cap the total withdrawn
// per session at WD_LIMIT; without it WD_LIMIT has no effect.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int PSW_WIDTH      = 16,
  parameter int BAL_WIDTH      = 20,
  parameter int CARD_WIDTH     = 6,
  parameter int NUM_ACCOUNTS   = 8,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int WD_LIMIT       = 5000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [CARD_WIDTH-1:0] cfg_idx,
  input  logic [PSW_WIDTH-1:0]  cfg_pin,
  input  logic [BAL_WIDTH-1:0]  cfg_balance,
  input  logic                  card_insert,
  input  logic [CARD_WIDTH-1:0] card_number,
  input  logic                  psw_valid,
  input  logic [PSW_WIDTH-1:0]  password_input,
  input  logic                  op_valid,
  input  logic [1:0]            operation,
  input  logic [BAL_WIDTH-1:0]  value,
  output logic [BAL_WIDTH-1:0]  balance_out,
  output logic                  op_done,
  output logic                  error,
  output logic                  wrong_psw,
  output logic                  card_locked,
  output logic                  card_eject,
  output logic                  session_active
);

  localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0]  TRY_MAX = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0]  TRY_ONE = TRY_W'(1);
  localparam logic [CARD_WIDTH:0] NUM_ACC = (CARD_WIDTH + 1)'(NUM_ACCOUNTS);

  // Account storage; cleared by reset so it lives in flops, not RAM.
  logic [PSW_WIDTH-1:0]    pin_mem_r [NUM_ACCOUNTS];
  logic [BAL_WIDTH-1:0]    bal_mem_r [NUM_ACCOUNTS];
  logic [TRY_W-1:0]        tries_r   [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_r;

  // Session registers.
  atm_state_t              state_r;
  logic [CARD_WIDTH-1:0]   card_r;
  logic [1:0]              op_r;
  logic [BAL_WIDTH-1:0]    value_r;

  logic [IDX_W-1:0]        card_idx_s;
  logic [IDX_W-1:0]        cfg_idx_s;
  logic                    card_ok_s;
  logic                    cfg_ok_s;
  logic [PSW_WIDTH-1:0]    cur_pin_s;
  logic [BAL_WIDTH-1:0]    cur_bal_s;
  logic [TRY_W-1:0]        tries_inc_s;
  logic [BAL_WIDTH:0]      dep_sum_s;
  logic                    wd_short_s;
  logic [BAL_WIDTH-1:0]    wd_diff_s;
  logic                    wd_cap_s;
  logic                    tmr_load_s;
  logic                    tmr_en_s;
  logic                    tmr_expire_s;

  assign card_idx_s  = card_r[IDX_W-1:0];
  assign cfg_idx_s   = cfg_idx[IDX_W-1:0];
  assign card_ok_s   = {1'b0, card_r} < NUM_ACC;
  assign cfg_ok_s    = {1'b0, cfg_idx} < NUM_ACC;
  assign cur_pin_s   = pin_mem_r[card_idx_s];
  assign cur_bal_s   = bal_mem_r[card_idx_s];
  assign tries_inc_s = tries_r[card_idx_s] + TRY_ONE;
  assign dep_sum_s   = {1'b0, cur_bal_s} + {1'b0, value_r};
  assign wd_short_s  = value_r > cur_bal_s;
  assign wd_diff_s   = cur_bal_s - value_r;

`ifdef ATM_DAILY_LIMIT_EN
  localparam logic [BAL_WIDTH+1:0] WD_CAP = (BAL_WIDTH + 2)'(WD_LIMIT);
  logic [BAL_WIDTH:0]   wd_acc_r;
  logic [BAL_WIDTH+1:0] wd_total_s;
  assign wd_total_s = {1'b0, wd_acc_r} + {2'b00, value_r};
  assign wd_cap_s   = wd_total_s > WD_CAP;
`else
  logic [31:0] wd_limit_unused_s;
  assign wd_limit_unused_s = 32'(WD_LIMIT);
  assign wd_cap_s          = 1'b0;
`endif

  // The timer stays reloaded outside the timed states and on every
  // accepted customer input, so entering a timed state starts a full window.
  assign tmr_en_s   = is_timed_state(state_r);
  assign tmr_load_s = !tmr_en_s
                    || ((state_r == ST_WAIT_PIN) && psw_valid)
                    || ((state_r == ST_MENU) && op_valid);

  atm_session_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load_s),
    .en     (tmr_en_s),
    .expire (tmr_expire_s)
  );

  // Session FSM with account storage updates and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      card_r         <= '0;
      op_r           <= OP_INQ;
      value_r        <= '0;
      lock_r         <= '0;
      balance_out    <= '0;
      op_done        <= 1'b0;
      error          <= 1'b0;
      wrong_psw      <= 1'b0;
      card_locked    <= 1'b0;
      card_eject     <= 1'b0;
      session_active <= 1'b0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_mem_r[i] <= '0;
        bal_mem_r[i] <= '0;
        tries_r[i]   <= '0;
      end
`ifdef ATM_DAILY_LIMIT_EN
      wd_acc_r       <= '0;
`endif
    end else begin
      op_done     <= 1'b0;
      error       <= 1'b0;
      wrong_psw   <= 1'b0;
      card_locked <= 1'b0;
      card_eject  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_we) begin
            if (cfg_ok_s) begin
              pin_mem_r[cfg_idx_s] <= cfg_pin;
              bal_mem_r[cfg_idx_s] <= cfg_balance;
              tries_r[cfg_idx_s]   <= '0;
              lock_r[cfg_idx_s]    <= 1'b0;
            end
          end else if (card_insert) begin
            card_r  <= card_number;
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!card_ok_s) begin
            error   <= 1'b1;
            state_r <= ST_EJECT;
          end else if (lock_r[card_idx_s]) begin
            card_locked <= 1'b1;
            state_r     <= ST_EJECT;
          end else begin
            session_active <= 1'b1;
            state_r        <= ST_WAIT_PIN;
`ifdef ATM_DAILY_LIMIT_EN
            wd_acc_r       <= '0;
`endif
          end
        end
        ST_WAIT_PIN: begin
          if (psw_valid) begin
            if (password_input == cur_pin_s) begin
              tries_r[card_idx_s] <= '0;
              balance_out         <= cur_bal_s;
              state_r             <= ST_MENU;
            end else begin
              wrong_psw           <= 1'b1;
              tries_r[card_idx_s] <= tries_inc_s;
              if (tries_inc_s >= TRY_MAX) begin
                lock_r[card_idx_s] <= 1'b1;
                card_locked        <= 1'b1;
                session_active     <= 1'b0;
                state_r            <= ST_EJECT;
              end
            end
          end else if (tmr_expire_s) begin
            error          <= 1'b1;
            session_active <= 1'b0;
            state_r        <= ST_EJECT;
          end
        end
        ST_MENU: begin
          if (op_valid) begin
            op_r    <= operation;
            value_r <= value;
            if (operation == OP_EXIT) begin
              session_active <= 1'b0;
              state_r        <= ST_EJECT;
            end else begin
              state_r <= ST_EXEC;
            end
          end else if (tmr_expire_s) begin
            error          <= 1'b1;
            session_active <= 1'b0;
            state_r        <= ST_EJECT;
          end
        end
        ST_EXEC: begin
          state_r <= ST_MENU;
          case (op_r)
            OP_INQ: op_done <= 1'b1;
            OP_DEP: begin
              if (dep_sum_s[BAL_WIDTH]) begin
                error <= 1'b1;
              end else begin
                bal_mem_r[card_idx_s] <= dep_sum_s[BAL_WIDTH-1:0];
                balance_out           <= dep_sum_s[BAL_WIDTH-1:0];
                op_done               <= 1'b1;
              end
            end
            OP_WD: begin
              if (wd_short_s || wd_cap_s) begin
                error <= 1'b1;
              end else begin
                bal_mem_r[card_idx_s] <= wd_diff_s;
                balance_out           <= wd_diff_s;
                op_done               <= 1'b1;
`ifdef ATM_DAILY_LIMIT_EN
                wd_acc_r              <= wd_total_s[BAL_WIDTH:0];
`endif
              end
            end
            default: error <= 1'b1;
          endcase
        end
        ST_EJECT: begin
          card_eject     <= 1'b1;
          card_r         <= '0;
          op_r           <= OP_INQ;
          value_r        <= '0;
          balance_out    <= '0;
          session_active <= 1'b0;
          state_r        <= ST_IDLE;
        end
        default: begin
          session_active <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl: directed scenarios followed by
// randomized sessions, all compared against an account-level model.
`timescale 1ns/1ps
module tb_atm_session_ctrl;
  import atm_pkg::*;

  localparam int PW = 16, BW = 20, CW = 6, NA = 8, MT = 3, TO = 20, WDL = 5000;
  localparam longint BAL_MAX = (64'd1 << BW) - 1;
`ifdef ATM_DAILY_LIMIT_EN
  localparam bit DAILY = 1'b1;
`else
  localparam bit DAILY = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b0;
  logic          cfg_we = 1'b0, card_insert = 1'b0, psw_valid = 1'b0, op_valid = 1'b0;
  logic [CW-1:0] cfg_idx = '0, card_number = '0;
  logic [PW-1:0] cfg_pin = '0, password_input = '0;
  logic [BW-1:0] cfg_balance = '0, value = '0, balance_out;
  logic [1:0]    operation = 2'b00;
  logic          op_done, error, wrong_psw, card_locked, card_eject, session_active;

  always #5 clk = ~clk;

  atm_session_ctrl #(.PSW_WIDTH(PW), .BAL_WIDTH(BW), .CARD_WIDTH(CW), .NUM_ACCOUNTS(NA),
                     .MAX_TRIES(MT), .TIMEOUT_CYCLES(TO), .WD_LIMIT(WDL)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pin(cfg_pin),
    .cfg_balance(cfg_balance), .card_insert(card_insert), .card_number(card_number),
    .psw_valid(psw_valid), .password_input(password_input), .op_valid(op_valid),
    .operation(operation), .value(value), .balance_out(balance_out), .op_done(op_done),
    .error(error), .wrong_psw(wrong_psw), .card_locked(card_locked),
    .card_eject(card_eject), .session_active(session_active));

  int tests_run = 0, tests_failed = 0;
  int n_done, n_err, n_wrong, n_lock, n_eject;

  // Reference model: per-account state plus the current session.
  logic [PW-1:0] m_pin [NA];
  longint        m_bal [NA];
  int            m_tries [NA];
  bit            m_lock [NA];
  int            m_card;
  longint        m_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_done = 0; n_err = 0; n_wrong = 0; n_lock = 0; n_eject = 0;
  endtask

  // One clock; outputs sampled 1ns after the edge and pulses tallied.
  task automatic tick();
    @(posedge clk); #1;
    n_done  += int'(op_done);
    n_err   += int'(error);
    n_wrong += int'(wrong_psw);
    n_lock  += int'(card_locked);
    n_eject += int'(card_eject);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_pin[i] = '0; m_bal[i] = 0; m_tries[i] = 0; m_lock[i] = 1'b0;
    end
    m_acc = 0;
  endtask

  task automatic do_cfg(input int idx, input logic [PW-1:0] pin, input longint bal, input bit with_card);
    clr_counts();
    cfg_we = 1'b1; cfg_idx = CW'(idx); cfg_pin = pin; cfg_balance = BW'(bal);
    card_insert = with_card; card_number = CW'(idx);
    tick();
    cfg_we = 1'b0; card_insert = 1'b0;
    if (idx < NA) begin
      m_pin[idx] = pin; m_bal[idx] = bal; m_tries[idx] = 0; m_lock[idx] = 1'b0;
    end
    if (with_card) begin
      tick(); tick();
      check_eq("cfg_prio_active", session_active, 0);
      check_eq("cfg_prio_pulses", n_err + n_lock + n_eject, 0);
    end
  endtask

  task automatic do_insert(input int card, output bit ok);
    int e_err, e_lock;
    clr_counts();
    card_insert = 1'b1; card_number = CW'(card);
    tick();
    card_insert = 1'b0;
    tick(); tick();
    e_err = 0; e_lock = 0; ok = 1'b0;
    if (card >= NA) e_err = 1;
    else if (m_lock[card]) e_lock = 1;
    else begin ok = 1'b1; m_card = card; m_acc = 0; end
    check_eq("insert_err", n_err, e_err);
    check_eq("insert_lock", n_lock, e_lock);
    check_eq("insert_eject", n_eject, ok ? 0 : 1);
    check_eq("insert_active", session_active, ok);
  endtask

  task automatic do_pin(input logic [PW-1:0] pin, output bit in_menu, output bit ejected);
    int e_wrong, e_lock;
    clr_counts();
    psw_valid = 1'b1; password_input = pin;
    tick();
    psw_valid = 1'b0;
    tick();
    e_wrong = 0; e_lock = 0; in_menu = 1'b0; ejected = 1'b0;
    if (pin == m_pin[m_card]) begin
      m_tries[m_card] = 0; in_menu = 1'b1;
    end else begin
      e_wrong = 1;
      m_tries[m_card]++;
      if (m_tries[m_card] >= MT) begin
        m_lock[m_card] = 1'b1; e_lock = 1; ejected = 1'b1;
      end
    end
    check_eq("pin_wrong", n_wrong, e_wrong);
    check_eq("pin_lock", n_lock, e_lock);
    check_eq("pin_eject", n_eject, ejected ? 1 : 0);
    check_eq("pin_active", session_active, !ejected);
    if (in_menu) check_eq("pin_balance", balance_out, 32'(m_bal[m_card]));
  endtask

  task automatic do_op(input logic [1:0] op, input longint val, output bit ejected);
    int e_done, e_err;
    longint b;
    b = m_bal[m_card];
    e_done = 0; e_err = 0; ejected = 1'b0;
    case (op)
      OP_INQ: e_done = 1;
      OP_DEP: if (b + val > BAL_MAX) e_err = 1;
              else begin m_bal[m_card] = b + val; e_done = 1; end
      OP_WD:  if (val > b || (DAILY && (m_acc + val > WDL))) e_err = 1;
              else begin m_bal[m_card] = b - val; m_acc += val; e_done = 1; end
      default: ejected = 1'b1;
    endcase
    clr_counts();
    op_valid = 1'b1; operation = op; value = BW'(val);
    tick();
    op_valid = 1'b0;
    tick();
    check_eq("op_done", n_done, e_done);
    check_eq("op_err", n_err, e_err);
    check_eq("op_eject", n_eject, ejected ? 1 : 0);
    check_eq("op_active", session_active, !ejected);
    if (!ejected) check_eq("op_balance", balance_out, 32'(m_bal[m_card]));
  endtask

  // Called one cycle into WAIT_PIN or MENU with no further input.
  task automatic wait_timeout(input string tag);
    clr_counts();
    repeat (TO - 2) tick();
    check_eq({tag, "_early"}, n_err + n_eject, 0);
    tick();
    check_eq({tag, "_err"}, n_err, 1);
    check_eq({tag, "_noeject"}, n_eject, 0);
    tick();
    check_eq({tag, "_eject"}, n_eject, 1);
    check_eq({tag, "_active"}, session_active, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, in_menu, ej;
    longint v, b;
    int c, k;
    logic [PW-1:0] p;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", {balance_out, op_done, error, wrong_psw, card_locked, card_eject, session_active}, 0);
    rst = 1'b1;
    tick();
    check_eq("post_rst_outputs", {balance_out, session_active}, 0);

    // Basic withdraw session.
    do_cfg(2, 16'h1234, 500, 1'b0);
    do_insert(2, ok);
    do_pin(16'h1234, in_menu, ej);
    do_op(OP_WD, 200, ej);
    check_eq("wd200_balance", balance_out, 300);
    do_op(OP_EXIT, 0, ej);

    // Lockout and locked reinsertion.
    do_insert(2, ok);
    for (int i = 0; i < MT; i++) do_pin(16'h1111, in_menu, ej);
    check_eq("locked_after_tries", ej, 1);
    do_insert(2, ok);
    check_eq("locked_reinsert", ok, 0);

    // Overdraw, deposit overflow, zero-value edges.
    do_cfg(2, 16'h1234, 300, 1'b0);
    do_insert(2, ok);
    do_pin(16'h1234, in_menu, ej);
    do_op(OP_WD, 301, ej);
    do_op(OP_EXIT, 0, ej);
    do_cfg(3, 16'hBEEF, BAL_MAX - 9, 1'b0);
    do_insert(3, ok);
    do_pin(16'hBEEF, in_menu, ej);
    do_op(OP_DEP, 10, ej);
    do_op(OP_DEP, 9, ej);
    check_eq("dep_full_balance", balance_out, 32'(BAL_MAX));
    do_op(OP_DEP, 0, ej);
    do_op(OP_WD, 0, ej);
    do_op(OP_INQ, 0, ej);
    do_op(OP_EXIT, 0, ej);

    // Invalid card and configuration corner cases.
    do_insert(9, ok);
    do_cfg(4, 16'h4444, 77, 1'b1);
    do_cfg(8, 16'h5555, 99, 1'b0);
    do_insert(0, ok);
    do_pin(16'h5555, in_menu, ej);
    do_pin(16'h0000, in_menu, ej);
    do_op(OP_EXIT, 0, ej);
    do_insert(4, ok);
    do_pin(16'h4444, in_menu, ej);
    do_op(OP_EXIT, 0, ej);

    // Inactivity timeouts and input in the expiry cycle.
    do_insert(2, ok);
    wait_timeout("to_pin");
    do_insert(2, ok);
    do_pin(16'h1234, in_menu, ej);
    wait_timeout("to_menu");
    do_insert(2, ok);
    do_pin(16'h1234, in_menu, ej);
    repeat (TO - 2) tick();
    do_op(OP_INQ, 0, ej);
    do_op(OP_EXIT, 0, ej);

    // Session withdrawal cap (effective only with the cap feature built in).
    do_cfg(5, 16'h0005, 9000, 1'b0);
    do_insert(5, ok);
    do_pin(16'h0005, in_menu, ej);
    do_op(OP_WD, 3000, ej);
    do_op(OP_WD, 2001, ej);
    do_op(OP_WD, 2000, ej);
    do_op(OP_EXIT, 0, ej);

    // Randomized sessions.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        c = int'($urandom_range(0, 9));
        b = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 20000)) : BAL_MAX - longint'($urandom_range(0, 50));
        do_cfg(c, PW'($urandom), b, $urandom_range(0, 4) == 0);
      end
      c = int'($urandom_range(0, 9));
      do_insert(c, ok);
      if (!ok) continue;
      in_menu = 1'b0; ej = 1'b0;
      while (!in_menu && !ej) begin
        p = m_pin[c];
        if ($urandom_range(0, 2) == 0) p = p ^ PW'($urandom_range(1, 16'hFFFF));
        do_pin(p, in_menu, ej);
      end
      if (ej) continue;
      k = int'($urandom_range(1, 5));
      for (int j = 0; j < k; j++) begin
        b = m_bal[c];
        case ($urandom_range(0, 4))
          0: v = 0;
          1: v = b;
          2: v = b + 1;
          3: v = longint'($urandom_range(0, 4000));
          default: v = longint'($urandom) & BAL_MAX;
        endcase
        if (v > BAL_MAX) v = BAL_MAX;
        do_op(2'($urandom_range(0, 2)), v, ej);
      end
      do_op(OP_EXIT, 0, ej);
    end

    // Asynchronous reset while executing an operation.
    do_cfg(2, 16'h1234, 9000, 1'b0);
    do_insert(2, ok);
    do_pin(16'h1234, in_menu, ej);
    op_valid = 1'b1; operation = OP_WD; value = BW'(100);
    tick();
    op_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("midexec_rst_outputs", {balance_out, op_done, error, wrong_psw, card_locked, card_eject, session_active}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    do_insert(2, ok);
    do_pin(16'h0000, in_menu, ej);
    check_eq("rst_cleared_balance", balance_out, 0);
    do_op(OP_EXIT, 0, ej);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
